// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers: ceil-log2 for address sizing, error flag payload, minimum depth.
package fifo_pkg;

  localparam int unsigned FIFO_MIN_DEPTH = 4;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with resettable output register.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty, programmable almost flags and fill count.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs and an err_clr input.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       afull,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       aempty,
`ifdef SYNC_FIFO_ERR_EN
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow,
`endif
  output logic [clog2(DEPTH):0]      count
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              wacc;
  logic              racc;
  logic [CNT_W-1:0]  count_nxt;

  // Requests are accepted only against the registered flags; no bypass in either direction.
  always_comb begin
    wacc      = wr_en && !full;
    racc      = rd_en && !empty;
    count_nxt = count + CNT_W'(wacc) - CNT_W'(racc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      afull    <= 1'b0;
      empty    <= 1'b1;
      aempty   <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      if (wacc) wptr <= wptr + ADDR_W'(1);
      if (racc) rptr <= rptr + ADDR_W'(1);
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(DEPTH));
      afull    <= (count_nxt >= CNT_W'(AFULL_TH));
      empty    <= (count_nxt == '0);
      aempty   <= (count_nxt <= CNT_W'(AEMPTY_TH));
      rd_valid <= racc;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wacc),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (racc),
    .raddr (rptr),
    .rdata (rd_data)
  );

`ifdef SYNC_FIFO_ERR_EN
  fifo_err_t err;

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err <= '0;
    end else begin
      if (wr_en && full)  err.overflow  <= 1'b1;
      if (rd_en && empty) err.underflow <= 1'b1;
    end
  end

  assign overflow  = err.overflow;
  assign underflow = err.underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (DEPTH=8, AFULL_TH=6, AEMPTY_TH=1); checks error flags when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              afull;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              aempty;
  logic              err_clr;
  logic              overflow;
  logic              underflow;
  logic [3:0]        count;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                m_cnt;
  logic [DATA_W-1:0] last_rd;
  logic              m_ov;
  logic              m_un;

  sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (6),
    .AEMPTY_TH (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .afull     (afull),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .aempty    (aempty),
`ifdef SYNC_FIFO_ERR_EN
    .err_clr   (err_clr),
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .count     (count)
  );

`ifndef SYNC_FIFO_ERR_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count",  32'(count),  32'(m_cnt));
    check("empty",  32'(empty),  32'(m_cnt == 0));
    check("full",   32'(full),   32'(m_cnt == DEPTH));
    check("afull",  32'(afull),  32'(m_cnt >= 6));
    check("aempty", 32'(aempty), 32'(m_cnt <= 1));
    check("rd_data", 32'(rd_data), 32'(last_rd));
`ifdef SYNC_FIFO_ERR_EN
    check("overflow",  32'(overflow),  32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    m_q.delete();
    exp_q.delete();
    m_cnt   = 0;
    last_rd = '0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; the model decides acceptance from its own fill level.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c = 1'b0);
    logic wa;
    logic ra;
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    err_clr = c;
    @(posedge clk);
    wa = w && (m_cnt < DEPTH);
    ra = r && (m_cnt > 0);
    if (c) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (w && m_cnt == DEPTH) m_ov = 1'b1;
      if (r && m_cnt == 0)     m_un = 1'b1;
    end
    if (ra) exp_q.push_back(m_q.pop_front());
    if (wa) m_q.push_back(d);
    m_cnt = m_q.size();
    #1;
    check("rd_valid", 32'(rd_valid), 32'(ra));
    if (ra && exp_q.size() > 0) last_rd = exp_q.pop_front();
    check_state();
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    m_cnt   = 0;
    last_rd = '0;
    m_ov    = 1'b0;
    m_un    = 1'b0;

    // Reset then idle
    do_reset();
    step(1'b0, 8'h00, 1'b0);

    // Fill with 0x01..0x08, then a dropped write
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);

    // Drain all eight, then an extra read on empty, then idle hold
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Steady state at count 4 across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h10 + i), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    // Full with both requests, then empty with both requests
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'hCC, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hDD, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Error flags: overflow, underflow, clear
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b1, 1'b1);

    // Reset mid-stream discards stored data
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    do_reset();
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
